main_fsm: RTL and testbench
===========================

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 Ports, in order:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; forces state FETCH.
- Op  in  2  Instr[27:26] from the instruction register.
- Funct  in  6  Instr[25:20]; Funct[5] is the immediate flag (I), Funct[0] is the load flag (L).
- IRWrite  out  1  instruction register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU-derived.
- ALUSrcA  out  2  SrcA select: 00 = A, 01 = PC, 10 = ALUOut.
- ALUSrcB  out  2  SrcB select: 00 = register, 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- NextPC  out  1  unconditional PC write request.
- RegW  out  1  register-write request, before condition gating.
- MemW  out  1  memory-write request, before condition gating.
- Branch  out  1  branch request, before condition gating.
- ALUOp  out  1  1 = ALU decoder uses Funct; 0 = force add.
- State  out  4  current state encoding, for debug and verification.

Function
REQ-003 SHALL be a Moore FSM: every output SHALL be a pure decode of the current state and SHALL NOT depend combinationally on Op or Funct.
REQ-004 State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10.
REQ-005 Codes 11-15 SHALL transition to FETCH on the next edge, with all outputs 0.
REQ-006 Outputs per state; any output not listed SHALL be 0, including don't-care fields:
- FETCH: IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1.
- EXECUTER: ALUOp=1.
- EXECUTEI: ALUSrcB=01, ALUOp=1.
- ALUWB: RegW=1.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1.
- UNKNOWN: all outputs 0.
REQ-007 Transitions, one per rising edge:
- FETCH -> DECODE.
- DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> UNKNOWN.
- MEMADR: Funct[0]=1 -> MEMRD; Funct[0]=0 -> MEMWR.
- MEMRD -> MEMWB.
- MEMWB, MEMWR, ALUWB, BRANCH and UNKNOWN -> FETCH.
- EXECUTER and EXECUTEI -> ALUWB.
REQ-008 Op and Funct SHALL be sampled only in DECODE and MEMADR and SHALL be ignored in every other state.
REQ-009 Instruction latency, from entering FETCH to the next FETCH:
- LDR: 5 cycles.
- STR: 4 cycles.
- Data-processing: 4 cycles.
- B: 3 cycles.
- Undefined: 3 cycles.
REQ-010 IRWrite SHALL be 1 in exactly one cycle per instruction (FETCH), so Op and Funct stay stable for the rest of the instruction.
REQ-011 In any state, at most one of RegW, MemW and Branch SHALL be 1.

Reset
REQ-012 When reset=1 at a rising edge, State SHALL become 0 (FETCH) regardless of current state or inputs; reset takes priority over every transition.
REQ-013 Reset SHALL have no asynchronous effect: before the first edge with reset=1, State is unspecified; after it, outputs equal the FETCH decode (IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10).
REQ-014 Reset asserted mid-instruction (for example in MEMWR) SHALL abort the instruction; MemW and RegW SHALL be 0 from the next cycle.

Verification
REQ-015 LDR: Op=01, Funct=011001 -> State sequence 0,1,2,3,4,0; RegW=1 only in state 4; ResultSrc=01 in state 4.
REQ-016 STR: Op=01, Funct=011000 -> State sequence 0,1,2,5,0; MemW=1 and AdrSrc=1 only in state 5.
REQ-017 ADD register, then ADD immediate: Op=00, Funct=001000 -> 0,1,6,8,0 with ALUOp=1 in state 6; then Funct=101000 -> 0,1,7,8,0 with ALUSrcB=01 in state 7.
REQ-018 B (Op=10) -> 0,1,9,0 with Branch=1, ALUSrcA=10, ALUSrcB=01 in state 9. Undefined (Op=11) -> 0,1,10,0 with all outputs 0 in state 10.
REQ-019 Reset in state 3 (MEMRD) -> State=0 on the next edge, with no RegW pulse. Force illegal code 13 -> State=0 on the next edge. Toggle Op and Funct during states 3 and 4 -> sequence unchanged.

Source files
------------

// File: rtl/main_fsm_if.sv
// Control-unit bus: the instruction fields feeding the main FSM and the
// per-state datapath control it returns, plus the current state for debug.
interface main_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic [3:0] State;

  // FSM side: consumes instruction fields, produces control
  modport slave (
    input  Op, Funct,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           NextPC, RegW, MemW, Branch, ALUOp, State
  );

  // Datapath / bench side: supplies instruction fields, observes control
  modport master (
    output Op, Funct,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           NextPC, RegW, MemW, Branch, ALUOp, State
  );
endinterface

// File: rtl/main_fsm.sv
// Multicycle main control FSM (Moore). Sequences fetch/decode/execute for
// LDR, STR, data-processing, branch and undefined instructions. All control
// outputs are decoded from the registered state only.
module main_fsm (
  input  logic     clk,
  input  logic     reset,
  main_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_e;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
  } ctrl_t;

  // Held as raw bits so the unused codes 11-15 stay representable and
  // are recovered to FETCH rather than assumed impossible.
  logic [3:0] state_q, state_d;
  ctrl_t      ctrl;

  // Funct[4:1] feed the ALU decoder, not this FSM.
  logic unused_funct_bits;
  assign unused_funct_bits = ^bus.Funct[4:1];

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state: Op/Funct are only looked at in DECODE and MEMADR
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:   state_d = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      // write-back, branch, undefined and illegal codes all return to fetch
      default:  state_d = FETCH;
    endcase
  end

  // Output decode: every field zero unless the state names it
  always_comb begin
    ctrl = '0;
    case (state_q)
      FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.next_pc    = 1'b1;
        ctrl.alu_src_a  = 2'b01;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
      end
      DECODE: begin
        ctrl.alu_src_a  = 2'b01;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
      end
      MEMADR: ctrl.alu_src_b = 2'b01;
      MEMRD:  ctrl.adr_src   = 1'b1;
      MEMWB: begin
        ctrl.result_src = 2'b01;
        ctrl.reg_w      = 1'b1;
      end
      MEMWR: begin
        ctrl.adr_src = 1'b1;
        ctrl.mem_w   = 1'b1;
      end
      EXECUTER: ctrl.alu_op = 1'b1;
      EXECUTEI: begin
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = 1'b1;
      end
      ALUWB: ctrl.reg_w = 1'b1;
      BRANCH: begin
        ctrl.alu_src_a  = 2'b10;
        ctrl.alu_src_b  = 2'b01;
        ctrl.result_src = 2'b10;
        ctrl.branch     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign bus.IRWrite   = ctrl.ir_write;
  assign bus.AdrSrc    = ctrl.adr_src;
  assign bus.ALUSrcA   = ctrl.alu_src_a;
  assign bus.ALUSrcB   = ctrl.alu_src_b;
  assign bus.ResultSrc = ctrl.result_src;
  assign bus.NextPC    = ctrl.next_pc;
  assign bus.RegW      = ctrl.reg_w;
  assign bus.MemW      = ctrl.mem_w;
  assign bus.Branch    = ctrl.branch;
  assign bus.ALUOp     = ctrl.alu_op;
  assign bus.State     = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: instruction-level model (class -> state path and
// latency) plus directed sequences with literal expectations, then a
// randomized instruction stream with random resets and input noise.
module tb_main_fsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  main_fsm_if bus();
  main_fsm dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  // instruction classes
  localparam int C_LDR = 0, C_STR = 1, C_DPR = 2, C_DPI = 3, C_B = 4, C_UND = 5;
  // states visited after DECODE, per class; latency FETCH->FETCH per class
  int path [6][3] = '{'{2, 3, 4}, '{2, 5, 0}, '{6, 8, 0}, '{7, 8, 0}, '{9, 0, 0}, '{10, 0, 0}};
  int lat  [6]    = '{5, 4, 4, 4, 3, 3};

  int pos = 0;   // cycles since entering FETCH
  int cls = 0;

  function automatic int classify(input logic [1:0] op, input logic [5:0] fn);
    case (op)
      2'b00:   return fn[5] ? C_DPI : C_DPR;
      2'b01:   return fn[0] ? C_LDR : C_STR;
      2'b10:   return C_B;
      default: return C_UND;
    endcase
  endfunction

  function automatic int exp_state();
    if (pos == 0) return 0;
    if (pos == 1) return 1;
    return path[cls][pos-2];
  endfunction

  // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp}
  function automatic logic [13:0] exp_out(input int st);
    case (st)
      0:       return 14'b1_0_01_10_10_1_0_0_0_0;
      1:       return 14'b0_0_01_10_10_0_0_0_0_0;
      2:       return 14'b0_0_00_01_00_0_0_0_0_0;
      3:       return 14'b0_1_00_00_00_0_0_0_0_0;
      4:       return 14'b0_0_00_00_01_0_1_0_0_0;
      5:       return 14'b0_1_00_00_00_0_0_1_0_0;
      6:       return 14'b0_0_00_00_00_0_0_0_0_1;
      7:       return 14'b0_0_00_01_00_0_0_0_0_1;
      8:       return 14'b0_0_00_00_00_0_1_0_0_0;
      9:       return 14'b0_0_10_01_10_0_0_0_1_0;
      default: return 14'b0;
    endcase
  endfunction

  // Instruction-level model: classify at the DECODE edge, then walk the path
  always @(posedge clk) begin
    if (reset)         pos <= 0;
    else if (pos == 0) pos <= 1;
    else if (pos == 1) begin
      cls <= classify(bus.Op, bus.Funct);
      pos <= 2;
    end
    else pos <= (pos + 1 == lat[cls]) ? 0 : pos + 1;
  end

  function automatic logic [13:0] act_out();
    return {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
            bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.ALUOp};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of DUT against the model
  task automatic cmp_cycle();
    int st;
    st = exp_state();
    chk("state+outputs", {14'd0, bus.State, act_out()}, {14'd0, st[3:0], exp_out(st)});
    chk("one_of_regw_memw_branch", 32'($countones({bus.RegW, bus.MemW, bus.Branch}) <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cmp_cycle();
  endtask

  // Directed instruction from FETCH; exp lists State per cycle ending in FETCH.
  // At index at_i the full output vector is compared against a literal.
  task automatic instr(input string name, input logic [1:0] op, input logic [5:0] fn,
                       input int exp[6], input int n, input int at_i,
                       input logic [13:0] at_v, input bit noise);
    bus.Op = op;
    bus.Funct = fn;
    chk({name, "_s0"}, 32'(bus.State), 32'(exp[0]));
    for (int i = 1; i < n; i++) begin
      tick();
      chk({name, "_seq"}, 32'(bus.State), 32'(exp[i]));
      chk({name, "_model"}, 32'(exp_state()), 32'(exp[i]));
      if (i == at_i) chk({name, "_outs"}, 32'(act_out()), 32'(at_v));
      if (noise && (exp[i] == 3 || exp[i] == 4)) begin
        bus.Op = 2'($urandom);
        bus.Funct = 6'($urandom);
      end
      if (exp[i] == 0) begin
        bus.Op = op;
        bus.Funct = fn;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.Op = 2'b00;
    bus.Funct = 6'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    cmp_cycle();
    chk("reset_state", 32'(bus.State), 32'd0);
    chk("reset_outs", 32'(act_out()), 32'(14'b1_0_01_10_10_1_0_0_0_0));
    reset = 1'b0;

    instr("ldr", 2'b01, 6'b011001, '{0, 1, 2, 3, 4, 0}, 6, 4, 14'b0_0_00_00_01_0_1_0_0_0, 1'b1);
    instr("str", 2'b01, 6'b011000, '{0, 1, 2, 5, 0, 0}, 5, 3, 14'b0_1_00_00_00_0_0_1_0_0, 1'b0);
    instr("addr", 2'b00, 6'b001000, '{0, 1, 6, 8, 0, 0}, 5, 2, 14'b0_0_00_00_00_0_0_0_0_1, 1'b0);
    instr("addi", 2'b00, 6'b101000, '{0, 1, 7, 8, 0, 0}, 5, 2, 14'b0_0_00_01_00_0_0_0_0_1, 1'b0);
    instr("b", 2'b10, 6'b000000, '{0, 1, 9, 0, 0, 0}, 4, 2, 14'b0_0_10_01_10_0_0_0_1_0, 1'b0);
    instr("und", 2'b11, 6'b000000, '{0, 1, 10, 0, 0, 0}, 4, 2, 14'b0, 1'b0);
    instr("decode_outs", 2'b10, 6'b111111, '{0, 1, 9, 0, 0, 0}, 4, 1, 14'b0_0_01_10_10_0_0_0_0_0, 1'b0);

    // reset while in MEMRD aborts the load: no RegW pulse
    bus.Op = 2'b01;
    bus.Funct = 6'b011001;
    tick(); tick(); tick();
    chk("memrd_reached", 32'(bus.State), 32'd3);
    reset = 1'b1;
    tick();
    chk("abort_state", 32'(bus.State), 32'd0);
    chk("abort_regw", 32'(bus.RegW), 32'd0);
    chk("abort_memw", 32'(bus.MemW), 32'd0);
    reset = 1'b0;

    // illegal code 13 recovers to FETCH on the next edge
    bus.Op = 2'b00;
    bus.Funct = 6'b001000;
    tick(); tick(); tick();
    chk("aluwb_reached", 32'(bus.State), 32'd8);
    #2 force dut.state_q = 4'd13;
    #1;
    chk("illegal_state", 32'(bus.State), 32'd13);
    chk("illegal_outs", 32'(act_out()), 32'd0);
    release dut.state_q;
    tick();
    chk("illegal_recover", 32'(bus.State), 32'd0);

    // random instruction stream with noise outside DECODE/MEMADR and random resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int st;
      st = exp_state();
      if (st == 0) begin
        bus.Op = 2'($urandom);
        bus.Funct = 6'($urandom);
      end
      else if (st != 1 && st != 2) begin
        bus.Op = 2'($urandom);
        bus.Funct = 6'($urandom);
      end
      reset = ($urandom_range(49) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
